video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Raster timing generator for the 1280x720 pong display path. Sweeps a pixel position across a 1650x750 total raster and produces `x`, `y` and `video_on` for the pong animation stage, plus `hsync`/`vsync` for the video output. It also produces one-cycle `line_tick`/`frame_tick` strobes so game-state updates can run as a clean clock enable in vertical blanking. All outputs are registered.

## Interface
- `H_ACTIVE`, 1280, active pixels per line
- `H_FP`, 110, horizontal front porch (pixels)
- `H_SYNC`, 40, hsync width (pixels)
- `H_BP`, 220, horizontal back porch (pixels)
- `V_ACTIVE`, 720, active lines per frame
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vsync width (lines)
- `V_BP`, 20, vertical back porch (lines)
- `SYNC_POL`, 1, asserted level of `hsync`/`vsync`; the inactive level is `~SYNC_POL`

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `pix_en`  in  1  pixel-advance enable; the raster steps one pixel on each `clk` edge where this is high
- `x`  out  16  current horizontal position, 0..H_TOTAL-1
- `y`  out  16  current vertical position, 0..V_TOTAL-1
- `video_on`  out  1  high when `x < H_ACTIVE` and `y < V_ACTIVE`
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `line_tick`  out  1  one-cycle strobe on entry to `x == 0`
- `frame_tick`  out  1  one-cycle strobe on entry to `(x, y) == (0, V_ACTIVE)`, i.e. the start of vertical blanking
- `frame_count`  out  16  count of completed frames

## Operation
- Derived constants:
  - `H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP` (1650).
  - `V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP` (750).
- Two counters, `hc` and `vc`, 16 bits each. They change only on edges where `pix_en == 1`.
- Advance rule:
  - If `hc == H_TOTAL-1`, then `hc` goes to 0.
  - Else `hc` increments.
  - `vc` changes only when `hc` wraps. At that point, if `vc == V_TOTAL-1`, `vc` goes to 0; else `vc` increments.
- `x` and `y` equal `hc` and `vc`. They are not masked during blanking.
- Sync asserted-level windows (inclusive):
  - `hsync` is at `SYNC_POL` when `hc` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. With defaults: 1390..1429.
  - `vsync` is at `SYNC_POL` when `vc` is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. With defaults: 725..729.
  - `vsync` is a function of `vc` only, so it changes on the edge where `hc` wraps to 0.
- `frame_count` increments when the raster wraps to (0,0). It wraps from 65535 to 0.
- Reset:
  - Counters reset to `(H_TOTAL-1, V_TOTAL-1)`, so the first enabled edge produces (0,0).
  - Output reset values:
    - `x` = 1649, `y` = 749
    - `video_on` = 0
    - `hsync` = `vsync` = `~SYNC_POL`
    - `line_tick` = `frame_tick` = 0
    - `frame_count` = 0
  - The first wrap to (0,0) after reset does increment `frame_count`, to 1.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). Ticks are cleared with no partial pulse. Nothing is retained.

## Timing
- Every output is a register. `video_on`, `hsync` and `vsync` are computed from next-state counter values, so on every cycle they are consistent with the `x`/`y` shown in that same cycle. They never lag by a cycle.
- Latency from `pix_en` sampled high to the new position on `x`/`y`: 1 clk.
- `line_tick` and `frame_tick`:
  - Each is high for exactly one `clk` cycle after the advancing edge that enters its position.
  - This holds even if `pix_en` stays low afterwards while the position is held.
- `pix_en == 0`: all outputs hold, and ticks are 0.
- With `pix_en` tied high:
  - Line period: 1650 clk.
  - Frame period: 1,237,500 clk.
  - `frame_tick` period: 1,237,500 clk.
- Simultaneous events:
  - At the (0,0) wrap, `line_tick` pulses and `frame_count` increments on the same edge.
  - At the (0, V_ACTIVE) entry, `line_tick` and `frame_tick` pulse in the same cycle.

## Test plan
- **Reset values:** assert `reset` asynchronously (no clock) -> `x`=1649, `y`=749, `video_on`=0, `hsync`=`vsync`=0, `frame_count`=0. Release with `pix_en`=1 -> the next cycle shows (0,0), `video_on`=1, `line_tick`=1, `frame_count`=1.
- **Line timing, `pix_en`=1:**
  - `video_on` is high for x=0..1279 and low for x=1280..1649.
  - `hsync` is high for exactly 40 cycles starting at x=1390.
  - `line_tick` period is 1650 cycles.
- **Frame timing, `pix_en`=1:**
  - `vsync` is high from the start of y=725 to the end of y=729 (8250 cycles).
  - `frame_tick` fires once at (0,720).
  - `frame_tick` period is 1,237,500 cycles.
  - `video_on` is 0 on every cycle with y ≥ 720.
- **`pix_en` toggling every other cycle:**
  - Line period becomes 3300 clk.
  - Each tick is high for exactly 1 clk.
  - `x`/`y` hold unchanged across disabled cycles.
- **Reset mid-frame:** assert `reset` at (700,400) while `line_tick` is clear -> outputs return to the reset values within the same cycle. Raster restarts from (0,0), with `frame_count` going 0 -> 1.
- **Wrap with reduced parameters:** H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1 -> frame is 35 cycles. Run 65,536 frames -> `frame_count` reads 65535 after 65,535 (0,0) wraps, then 0 on the next.

Source files
------------

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// video_timing_gen_if : raster position / sync / strobe bundle
// Rev 1.0
// ============================================================================
interface video_timing_gen_if;
    logic        pix_en;
    logic [15:0] x;
    logic [15:0] y;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        line_tick;
    logic        frame_tick;
    logic [15:0] frame_count;

    modport master (
        input  pix_en,
        output x, y, video_on, hsync, vsync, line_tick, frame_tick, frame_count
    );

    modport slave (
        output pix_en,
        input  x, y, video_on, hsync, vsync, line_tick, frame_tick, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : raster sweep, syncs and line/frame strobes, all registered
// Rev 1.0
// ============================================================================
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter logic        SYNC_POL = 1'b1
) (
    input wire                 clk,
    input wire                 reset,
    video_timing_gen_if.master vt
);
    localparam int unsigned c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [15:0] c_h_last   = 16'(c_h_total - 1);
    localparam logic [15:0] c_v_last   = 16'(c_v_total - 1);
    localparam logic [15:0] c_h_act    = 16'(H_ACTIVE);
    localparam logic [15:0] c_v_act    = 16'(V_ACTIVE);
    localparam logic [15:0] c_hs_first = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] c_hs_last  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] c_vs_first = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] c_vs_last  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [15:0] hc_q, hc_d;
    logic [15:0] vc_q, vc_d;
    logic [15:0] fc_q, fc_d;
    logic        vo_q, vo_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        lt_q, lt_d;
    logic        ft_q, ft_d;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        fc_d = fc_q;
        vo_d = vo_q;
        hs_d = hs_q;
        vs_d = vs_q;
        lt_d = 1'b0;
        ft_d = 1'b0;
        if (vt.pix_en) begin
            if (hc_q == c_h_last) begin
                hc_d = 16'd0;
                lt_d = 1'b1;
                if (vc_q == c_v_last) begin
                    vc_d = 16'd0;
                    fc_d = fc_q + 16'd1;
                end else begin
                    vc_d = vc_q + 16'd1;
                end
                ft_d = (vc_d == c_v_act);
            end else begin
                hc_d = hc_q + 16'd1;
            end
            // Decoded from the next position so they line up with x/y in the same cycle
            vo_d = (hc_d < c_h_act) && (vc_d < c_v_act);
            hs_d = ((hc_d >= c_hs_first) && (hc_d <= c_hs_last)) ? SYNC_POL : ~SYNC_POL;
            vs_d = ((vc_d >= c_vs_first) && (vc_d <= c_vs_last)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q <= c_h_last;
            vc_q <= c_v_last;
            fc_q <= 16'd0;
            vo_q <= 1'b0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            lt_q <= 1'b0;
            ft_q <= 1'b0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            fc_q <= fc_d;
            vo_q <= vo_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            lt_q <= lt_d;
            ft_q <= ft_d;
        end
    end

    assign vt.x           = hc_q;
    assign vt.y           = vc_q;
    assign vt.video_on    = vo_q;
    assign vt.hsync       = hs_q;
    assign vt.vsync       = vs_q;
    assign vt.line_tick   = lt_q;
    assign vt.frame_tick  = ft_q;
    assign vt.frame_count = fc_q;
endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_video_timing_gen : directed checks on a 1650x750, a 7x5 and a 1x1 raster
// Rev 1.0
// ============================================================================
module tb_video_timing_gen;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen_if ifa ();
    video_timing_gen_if ifb ();
    video_timing_gen_if ifc ();

    video_timing_gen u_a (.clk(clk), .reset(reset), .vt(ifa.master));

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_b (.clk(clk), .reset(reset), .vt(ifb.master));

    video_timing_gen #(
        .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0)
    ) u_c (.clk(clk), .reset(reset), .vt(ifc.master));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ax, ay, afc;
    int bx, by, bfc;
    int last_lt, last_ft, vo_cnt, hs_cnt, vs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv_a();
        if (ax == 1649) begin
            ax = 0;
            if (ay == 749) begin ay = 0; afc = (afc + 1) % 65536; end
            else ay++;
        end else ax++;
    endtask

    task automatic adv_b();
        if (bx == 6) begin
            bx = 0;
            if (by == 4) begin by = 0; bfc = (bfc + 1) % 65536; end
            else by++;
        end else bx++;
    endtask

    task automatic chk_a(input bit adv);
        chk("a_x", 32'(ifa.x), ax);
        chk("a_y", 32'(ifa.y), ay);
        chk("a_video_on", 32'(ifa.video_on), 32'(ax < 1280 && ay < 720));
        chk("a_hsync", 32'(ifa.hsync), 32'(ax >= 1390 && ax <= 1429));
        chk("a_vsync", 32'(ifa.vsync), 32'(ay >= 725 && ay <= 729));
        chk("a_line_tick", 32'(ifa.line_tick), 32'(adv && ax == 0));
        chk("a_frame_tick", 32'(ifa.frame_tick), 32'(adv && ax == 0 && ay == 720));
        chk("a_frame_count", 32'(ifa.frame_count), afc);
    endtask

    task automatic chk_b(input bit adv);
        chk("b_x", 32'(ifb.x), bx);
        chk("b_y", 32'(ifb.y), by);
        chk("b_video_on", 32'(ifb.video_on), 32'(bx < 4 && by < 2));
        chk("b_hsync", 32'(ifb.hsync), 32'(bx == 5));
        chk("b_vsync", 32'(ifb.vsync), 32'(by == 3));
        chk("b_line_tick", 32'(ifb.line_tick), 32'(adv && bx == 0));
        chk("b_frame_tick", 32'(ifb.frame_tick), 32'(adv && bx == 0 && by == 2));
        chk("b_frame_count", 32'(ifb.frame_count), bfc);
    endtask

    task automatic chk_rst(input string n, input logic [15:0] x, input logic [15:0] y,
                           input logic vo, input logic hs, input logic vs,
                           input logic lt, input logic ft, input logic [15:0] fc,
                           input int ex, input int ey);
        chk({n, "_rst_x"}, 32'(x), ex);
        chk({n, "_rst_y"}, 32'(y), ey);
        chk({n, "_rst_video_on"}, 32'(vo), 0);
        chk({n, "_rst_hsync"}, 32'(hs), 0);
        chk({n, "_rst_vsync"}, 32'(vs), 0);
        chk({n, "_rst_line_tick"}, 32'(lt), 0);
        chk({n, "_rst_frame_tick"}, 32'(ft), 0);
        chk({n, "_rst_frame_count"}, 32'(fc), 0);
    endtask

    task automatic lt_period(input int per);
        if (ifa.line_tick) begin
            if (last_lt >= 0) chk("a_line_period", cyc - last_lt, per);
            last_lt = cyc;
        end
    endtask

    initial begin
        ifa.pix_en = 1'b0;
        ifb.pix_en = 1'b0;
        ifc.pix_en = 1'b0;

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        chk_rst("a", ifa.x, ifa.y, ifa.video_on, ifa.hsync, ifa.vsync,
                ifa.line_tick, ifa.frame_tick, ifa.frame_count, 1649, 749);
        chk_rst("b", ifb.x, ifb.y, ifb.video_on, ifb.hsync, ifb.vsync,
                ifb.line_tick, ifb.frame_tick, ifb.frame_count, 6, 4);
        chk_rst("c", ifc.x, ifc.y, ifc.video_on, ifc.hsync, ifc.vsync,
                ifc.line_tick, ifc.frame_tick, ifc.frame_count, 0, 0);

        @(negedge clk);
        reset = 1'b0;
        ifa.pix_en = 1'b1;
        ax = 1649; ay = 749; afc = 0;

        // Two full lines with pix_en high
        last_lt = -1; vo_cnt = 0; hs_cnt = 0;
        for (int i = 0; i < 3300; i++) begin
            tick();
            adv_a();
            chk_a(1'b1);
            lt_period(1650);
            if (ax == 0) begin vo_cnt = 0; hs_cnt = 0; end
            vo_cnt += 32'(ifa.video_on);
            hs_cnt += 32'(ifa.hsync);
            if (ax == 1649) begin
                chk("a_video_on_cycles", vo_cnt, 1280);
                chk("a_hsync_cycles", hs_cnt, 40);
            end
        end

        // pix_en toggling every other cycle
        last_lt = -1;
        for (int i = 0; i < 7000; i++) begin
            bit en;
            en = (i % 2 == 0);
            ifa.pix_en = en;
            tick();
            if (en) adv_a();
            chk_a(en);
            lt_period(3300);
        end

        // Mid-line reset at x == 700
        ifa.pix_en = 1'b1;
        for (int i = 0; i < 2000 && ax != 700; i++) begin
            tick();
            adv_a();
            chk_a(1'b1);
        end
        chk("a_mid_x", 32'(ifa.x), 700);
        chk("a_mid_line_tick", 32'(ifa.line_tick), 0);
        #2 reset = 1'b1;
        #1;
        chk_rst("a_mid", ifa.x, ifa.y, ifa.video_on, ifa.hsync, ifa.vsync,
                ifa.line_tick, ifa.frame_tick, ifa.frame_count, 1649, 749);
        @(negedge clk);
        reset = 1'b0;
        ax = 1649; ay = 749; afc = 0;
        tick();
        adv_a();
        chk_a(1'b1);
        chk("a_restart_frame_count", 32'(ifa.frame_count), 1);
        ifa.pix_en = 1'b0;

        // Small raster: 7x5 frame of 35 cycles
        bx = 6; by = 4; bfc = 0;
        last_ft = -1; vs_cnt = 0;
        ifb.pix_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            adv_b();
            chk_b(1'b1);
            if (bx == 0 && by == 0) vs_cnt = 0;
            vs_cnt += 32'(ifb.vsync);
            if (bx == 6 && by == 4) chk("b_vsync_cycles", vs_cnt, 7);
            if (ifb.frame_tick) begin
                if (last_ft >= 0) chk("b_frame_period", cyc - last_ft, 35);
                last_ft = cyc;
            end
        end
        chk("b_end_frame_tick", 32'(ifb.frame_tick), 1);
        ifb.pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_b(1'b0);
        end

        // 1x1 raster: every enabled edge wraps to (0,0), exercising frame_count wrap
        ifc.pix_en = 1'b1;
        for (int k = 1; k <= 65536; k++) begin
            tick();
            if (k == 1) begin
                chk("c_first_x", 32'(ifc.x), 0);
                chk("c_first_y", 32'(ifc.y), 0);
                chk("c_first_video_on", 32'(ifc.video_on), 1);
                chk("c_first_line_tick", 32'(ifc.line_tick), 1);
                chk("c_first_frame_count", 32'(ifc.frame_count), 1);
            end
            if (k == 65535) chk("c_frame_count_max", 32'(ifc.frame_count), 65535);
            if (k == 65536) begin
                chk("c_frame_count_wrap", 32'(ifc.frame_count), 0);
                chk("c_wrap_hsync", 32'(ifc.hsync), 0);
                chk("c_wrap_vsync", 32'(ifc.vsync), 0);
            end
        end
        ifc.pix_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
